dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the single-cycle ARM core and one external bus master (loader, DMA or video reader). Requests are arbitrated per cycle. The core is stalled while it waits, and the external master gets a valid/ready handshake. The block sits between `arm_top`'s data-memory port (`DataAdr`/`WriteData`/`MemWrite`) and a synchronous RAM with one-cycle read latency.

## Interface

Parameters:
- `ADDR_W`, 32, address width for both requesters and the memory.
- `DATA_W`, 32, data width.
- `MAX_WAIT`, 4, fixed-priority mode only: cycles the external master may lose before it is forced to win.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  core performs a data access this cycle.
- `cpu_we`  in  1  core write (`MemWrite`).
- `cpu_addr`  in  ADDR_W  core address (`DataAdr`).
- `cpu_wdata`  in  DATA_W  core write data (`WriteData`).
- `cpu_rdata`  out  DATA_W  core read data.
- `cpu_stall`  out  1  freezes core PC/register writes.
- `ext_valid`  in  1  external request pending.
- `ext_we`  in  1  external write.
- `ext_addr`  in  ADDR_W  external address.
- `ext_wdata`  in  DATA_W  external write data.
- `ext_ready`  out  1  external request accepted this cycle.
- `ext_rdata`  out  DATA_W  external read data.
- `ext_rvalid`  out  1  `ext_rdata` valid.
- `mem_en`  out  1  RAM access strobe.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data, valid the cycle after the read is issued.

## Operation

- States:
  - `IDLE`: no read outstanding.
  - `CPU_RD`: core read issued last cycle.
  - `EXT_RD`: external read issued last cycle.
- Every cycle exactly one of {cpu, ext, none} is granted. The grant drives `mem_*` combinationally from the winner's inputs. `mem_en` = 1 iff a grant is made.
- Eligibility:
  - cpu is eligible iff `cpu_req` and state ≠ `CPU_RD`. In `CPU_RD` the core's held request is the one being completed.
  - ext is eligible iff `ext_valid`.
- Core write, granted: completes that cycle, `cpu_stall`=0. Next state `IDLE` (or `EXT_RD`/`CPU_RD` per the new grant).
- Core read, granted in cycle N: `cpu_stall`=1 in N. In N+1, state is `CPU_RD`, `cpu_rdata`=`mem_rdata`, `cpu_stall`=0.
- Core not granted while eligible: `cpu_stall`=1.
- External request: `ext_ready`=1 in the grant cycle; the transfer happens on `ext_valid & ext_ready`. A read pulses `ext_rvalid`=1 in the next cycle with `ext_rdata`=`mem_rdata`.
- State `CPU_RD` or `EXT_RD` does not block a new grant in the same cycle; the RAM port is free then. Back-to-back reads give 100% port utilisation.
- Next state = `CPU_RD` / `EXT_RD` if a read is granted this cycle, else `IDLE`.
- Fixed-priority arbitration (default):
  - cpu wins ties.
  - A 3-bit-saturating `wait_cnt` increments each cycle ext is eligible but loses, and clears when ext is granted.
  - When `wait_cnt` ≥ `MAX_WAIT`, ext wins the next tie.

## Timing

- Reset (`reset`=0, asynchronous): state `IDLE`, `wait_cnt`=0, `last_grant`=ext. Every output is 0: `cpu_stall`, `cpu_rdata`, `ext_ready`, `ext_rdata`, `ext_rvalid`, and all `mem_*`.
- Reset asserted mid-read: the pending read is dropped, and no `ext_rvalid` or read completion follows release.
- Outputs:
  - `mem_*`, `cpu_stall` and `ext_ready` are combinational from the inputs and state.
  - `cpu_rdata`/`ext_rdata` are combinational pass-throughs of `mem_rdata`, gated by state; they are 0 when not valid.
- Latency, uncontended:
  - Core write: 0 stall cycles.
  - Core read: 1 stall cycle.
  - External read: `ext_rvalid` 1 cycle after the handshake.
- Simultaneous ext write and core read to the same address: the winner's order defines the result. A write granted before the read is visible to that read.
- `ext_valid` deasserted before `ext_ready`: no access, no error.

## Configuration

- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last_grant` register records the most recent winner.
  - On a tie, the requester that did not win last wins.
  - `wait_cnt` and `MAX_WAIT` are unused.
- `DMEM_ARB_RR_EN` undefined: fixed core priority with the `MAX_WAIT` starvation guard, as in Operation.

## Test plan

- Core-only traffic (default build): write 7 to 0x64, then read 0x64 → write has no stall; read stalls exactly 1 cycle and returns 7; `ext_ready` stays 0.
- External-only traffic: write 0xDEADBEEF to 0x60, then read 0x60 → `ext_ready`=1 in each request cycle; `ext_rvalid`=1 with 0xDEADBEEF exactly one cycle after the read handshake.
- Contention, default build, `MAX_WAIT`=4: `cpu_req` and `ext_valid` held high for 12 cycles → core wins 4 grants, ext wins the 5th, and the pattern repeats; `cpu_stall`=1 exactly in the ext-grant cycles and in the core read-issue cycles.
- Contention with `DMEM_ARB_RR_EN`: both requesting reads continuously → grants alternate cpu/ext starting with cpu after reset; `mem_en`=1 every cycle.
- Reset mid-operation: assert `reset`=0 one cycle after an ext read handshake → `ext_rvalid` never pulses; all outputs read 0 during reset; the first request after release is served normally.
- Ordering: ext writes 0x55 to 0x80 in the same cycle the core requests a read of 0x80 (default build) → core reads the old value, then the ext write completes; a subsequent core read returns 0x55.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous RAM (1-cycle read latency)
// between the single-cycle ARM core and one external bus master.
// Default build: fixed core priority with a MAX_WAIT starvation guard.
// Define DMEM_ARB_RR_EN to switch tie-breaking to round-robin.
//
// Handshake: the external transfer happens in the cycle where
// ext_valid & ext_ready are both 1; ext_ready is combinational from
// ext_valid and the arbiter state, and a read returns ext_rdata with a
// one-cycle ext_rvalid pulse in the following cycle. The core side is a
// stall interface: cpu_stall=1 holds the core, which keeps its request
// stable until the stall drops.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ext_valid,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_ready,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        dbg_state
);

   // IDLE: no read outstanding; CPU_RD/EXT_RD: that requester's read was
   // issued last cycle and its data is on mem_rdata now.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      EXT_RD = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   cpu_elig, ext_elig;
   logic   grant_cpu, grant_ext;
   logic   ext_wins_tie;

   assign dbg_state = state_q;

`ifdef DMEM_ARB_RR_EN
   // last_grant_q: 1 = ext won most recently, 0 = cpu. Reset to ext so the
   // core takes the first tie.
   logic last_grant_q, last_grant_d;

   assign ext_wins_tie = ~last_grant_q;

   // Remember the most recent winner; hold when nobody is granted.
   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_ext)      last_grant_d = 1'b1;
      else if (grant_cpu) last_grant_d = 1'b0;
   end

   // Round-robin history register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) last_grant_q <= 1'b1;
      else        last_grant_q <= last_grant_d;
   end
`else
   // A MAX_WAIT above the counter range saturates at 7 so the guard still fires.
   localparam int              MAX_WAIT_SAT = (MAX_WAIT > 7) ? 7 : MAX_WAIT;
   localparam logic [2:0]      MAX_WAIT_C   = 3'(MAX_WAIT_SAT);
   logic [2:0] wait_cnt_q, wait_cnt_d;

   assign ext_wins_tie = (wait_cnt_q >= MAX_WAIT_C);

   // Count cycles ext was eligible but lost; clear on an ext grant.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (grant_ext)                             wait_cnt_d = 3'd0;
      else if (ext_elig && wait_cnt_q != 3'd7)   wait_cnt_d = wait_cnt_q + 3'd1;
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wait_cnt_q <= 3'd0;
      else        wait_cnt_q <= wait_cnt_d;
   end
`endif

   // Eligibility and grant; reset masks both requesters so every output is 0.
   always_comb begin
      cpu_elig  = reset & cpu_req & (state_q != CPU_RD);
      ext_elig  = reset & ext_valid;
      grant_cpu = 1'b0;
      grant_ext = 1'b0;
      if (cpu_elig && ext_elig) begin
         grant_ext = ext_wins_tie;
         grant_cpu = ~ext_wins_tie;
      end else begin
         grant_cpu = cpu_elig;
         grant_ext = ext_elig;
      end
   end

   // State register; a reset drops any outstanding read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: a granted read is completed next cycle, anything else idles.
   always_comb begin
      state_d = IDLE;
      if (grant_cpu && !cpu_we)      state_d = CPU_RD;
      else if (grant_ext && !ext_we) state_d = EXT_RD;
   end

   // Outputs: RAM port from the winner, stall/ready, state-gated read data.
   always_comb begin
      mem_en    = grant_cpu | grant_ext;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_cpu) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (grant_ext) begin
         mem_we    = ext_we;
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
      end
      // A granted write finishes this cycle; a read or a lost request waits.
      cpu_stall  = cpu_elig & ~(grant_cpu & cpu_we);
      ext_ready  = grant_ext;
      cpu_rdata  = (state_q == CPU_RD) ? mem_rdata : '0;
      ext_rvalid = (state_q == EXT_RD);
      ext_rdata  = (state_q == EXT_RD) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model (per-requester pending read, loss
// count / last winner, and a reference memory image).
module tb_dmem_arbiter;
   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int MAX_WAIT = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic          cpu_req, cpu_we, ext_valid, ext_we;
   logic [AW-1:0] cpu_addr, ext_addr, mem_addr;
   logic [DW-1:0] cpu_wdata, ext_wdata, mem_wdata, cpu_rdata, ext_rdata;
   logic [DW-1:0] mem_rdata;
   logic          cpu_stall, ext_ready, ext_rvalid, mem_en, mem_we;
   logic [1:0]    dbg_state;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr),
      .ext_wdata(ext_wdata), .ext_ready(ext_ready), .ext_rdata(ext_rdata),
      .ext_rvalid(ext_rvalid), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .dbg_state(dbg_state)
   );

   // Synchronous RAM, one-cycle read latency, 256 words indexed by addr[7:0].
   logic [DW-1:0] ram [256];
   initial begin
      foreach (ram[i]) ram[i] = '0;
      mem_rdata = '0;
   end
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[7:0]];
      end
   end

   // ---------------- scoreboard / model state ----------------
   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] exp_q[$];      // ext read data due next cycle
   logic [DW-1:0] cpu_exp_q[$];  // core read data due next cycle
   bit            m_cpu_pend, m_ext_pend, m_last_ext;
   int            m_losses;
   bit            g_cpu, g_ext;
   int            ext_grants = 0, cpu_grants = 0, stall_cycles = 0, en_cycles = 0;
   logic [DW-1:0] obs_cpu_rdata, obs_ext_rdata;
   logic          obs_ext_rvalid, obs_ext_ready;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_cpu_pend = 0;
      m_ext_pend = 0;
      m_last_ext = 1;
      m_losses   = 0;
      exp_q.delete();
      cpu_exp_q.delete();
   endtask

   // Decide the grant from the rules and compare every output (at negedge).
   task automatic eval_check();
      bit cw, ew, ext_tie;
      logic [DW-1:0] e;
      obs_cpu_rdata  = cpu_rdata;
      obs_ext_rdata  = ext_rdata;
      obs_ext_rvalid = ext_rvalid;
      obs_ext_ready  = ext_ready;
      if (!reset) begin
         g_cpu = 0;
         g_ext = 0;
         model_clear();
         check("rst_mem_en", mem_en, 0);
         check("rst_mem_we", mem_we, 0);
         check("rst_mem_addr", mem_addr, 0);
         check("rst_mem_wdata", mem_wdata, 0);
         check("rst_cpu_stall", cpu_stall, 0);
         check("rst_cpu_rdata", cpu_rdata, 0);
         check("rst_ext_ready", ext_ready, 0);
         check("rst_ext_rvalid", ext_rvalid, 0);
         check("rst_ext_rdata", ext_rdata, 0);
         return;
      end
      cw = cpu_req && !m_cpu_pend;
      ew = ext_valid;
`ifdef DMEM_ARB_RR_EN
      ext_tie = !m_last_ext;
`else
      ext_tie = (m_losses >= MAX_WAIT);
`endif
      g_cpu = cw && !(ew && ext_tie);
      g_ext = ew && !(cw && !ext_tie);
      check("mem_en", mem_en, g_cpu || g_ext);
      check("mem_we", mem_we, g_cpu ? cpu_we : (g_ext ? ext_we : 1'b0));
      check("mem_addr", mem_addr, g_cpu ? cpu_addr : (g_ext ? ext_addr : '0));
      check("mem_wdata", mem_wdata, g_cpu ? cpu_wdata : (g_ext ? ext_wdata : '0));
      check("cpu_stall", cpu_stall, cw && !(g_cpu && cpu_we));
      check("ext_ready", ext_ready, g_ext);
      if (m_cpu_pend) begin
         e = cpu_exp_q.pop_front();
         check("cpu_rdata", cpu_rdata, e);
      end else begin
         check("cpu_rdata_idle", cpu_rdata, 0);
      end
      if (m_ext_pend) begin
         e = exp_q.pop_front();
         check("ext_rvalid", ext_rvalid, 1);
         check("ext_rdata", ext_rdata, e);
      end else begin
         check("ext_rvalid_idle", ext_rvalid, 0);
         check("ext_rdata_idle", ext_rdata, 0);
      end
      if (g_ext) ext_grants++;
      if (g_cpu) cpu_grants++;
      if (cpu_stall) stall_cycles++;
      if (mem_en) en_cycles++;
   endtask

   // Apply the decided grant to the model at the clock edge.
   task automatic commit();
      if (!reset) begin
         model_clear();
         return;
      end
      if (g_cpu) begin
         if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
         else        cpu_exp_q.push_back(ref_mem[cpu_addr[7:0]]);
      end
      if (g_ext) begin
         if (ext_we) ref_mem[ext_addr[7:0]] = ext_wdata;
         else        exp_q.push_back(ref_mem[ext_addr[7:0]]);
      end
      m_cpu_pend = g_cpu && !cpu_we;
      m_ext_pend = g_ext && !ext_we;
      if (g_ext)                          m_losses = 0;
      else if (ext_valid && m_losses < 7) m_losses++;
      if (g_ext)      m_last_ext = 1;
      else if (g_cpu) m_last_ext = 0;
   endtask

   task automatic step();
      @(negedge clk);
      eval_check();
      @(posedge clk);
      commit();
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic drive_ext(input logic v, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
      ext_valid = v; ext_we = we; ext_addr = a; ext_wdata = d;
   endtask

   task automatic idle();
      drive_cpu(0, 0, '0, '0);
      drive_ext(0, 0, '0, '0);
   endtask

   int e0, c0, s0, n0;

   initial begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      model_clear();
      reset = 1'b0;
      idle();
      step();
      step();
      reset = 1'b1;
      step();

      // Core-only: write 7 to 0x64, then read it back.
      e0 = ext_grants;
      drive_cpu(1, 1, 32'h64, 32'd7);
      step();
      drive_cpu(1, 0, 32'h64, '0);
      step();
      step();
      check("core_rd_value", obs_cpu_rdata, 32'd7);
      check("core_no_ext_ready", ext_grants - e0, 0);
      idle();
      step();

      // External-only: write 0xDEADBEEF to 0x60, then read it.
      drive_ext(1, 1, 32'h60, 32'hDEADBEEF);
      step();
      check("ext_wr_ready", obs_ext_ready, 1);
      drive_ext(1, 0, 32'h60, '0);
      step();
      check("ext_rd_ready", obs_ext_ready, 1);
      idle();
      step();
      check("ext_rd_rvalid", obs_ext_rvalid, 1);
      check("ext_rd_value", obs_ext_rdata, 32'hDEADBEEF);

      // Contention with writes held for 12 cycles.
      e0 = ext_grants; s0 = stall_cycles;
      drive_cpu(1, 1, 32'h10, 32'h1111);
      drive_ext(1, 1, 32'h20, 32'h2222);
      for (int i = 0; i < 12; i++) step();
      idle();
      step();
`ifdef DMEM_ARB_RR_EN
      check("cont_wr_ext_grants", ext_grants - e0, 6);
      check("cont_wr_stalls", stall_cycles - s0, 6);
`else
      check("cont_wr_ext_grants", ext_grants - e0, 2);
      check("cont_wr_stalls", stall_cycles - s0, 2);
`endif

      // Contention with reads: grants alternate, RAM port busy every cycle.
      e0 = ext_grants; c0 = cpu_grants; n0 = en_cycles;
      drive_cpu(1, 0, 32'h64, '0);
      drive_ext(1, 0, 32'h60, '0);
      for (int i = 0; i < 8; i++) step();
      idle();
      step();
      check("cont_rd_mem_en", en_cycles - n0, 8);
      check("cont_rd_cpu_grants", cpu_grants - c0, 4);
      check("cont_rd_ext_grants", ext_grants - e0, 4);

      // Reset one cycle after an ext read handshake: no rvalid follows.
      drive_ext(1, 0, 32'h60, '0);
      step();
      reset = 1'b0;
      idle();
      step();
      check("rst_mid_no_rvalid", obs_ext_rvalid, 0);
      step();
      reset = 1'b1;
      step();
      check("post_rst_no_rvalid", obs_ext_rvalid, 0);
      drive_cpu(1, 0, 32'h64, '0);
      step();
      step();
      check("post_rst_core_rd", obs_cpu_rdata, 32'd7);
      idle();
      step();

      // Ordering: ext write to 0x80 races a core read of 0x80.
      drive_cpu(1, 0, 32'h80, '0);
      drive_ext(1, 1, 32'h80, 32'h55);
      step();
      step();
`ifndef DMEM_ARB_RR_EN
      check("order_old_value", obs_cpu_rdata, 32'h0);
      check("order_ext_wr_ready", obs_ext_ready, 1);
`endif
      idle();
      step();
      step();
      drive_cpu(1, 0, 32'h80, '0);
      step();
      step();
      check("order_new_value", obs_cpu_rdata, 32'h55);
      idle();
      step();

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         drive_cpu($urandom_range(0, 1), $urandom_range(0, 1),
                   AW'({$urandom_range(0, 31), 2'b00}), $urandom);
         drive_ext($urandom_range(0, 1), $urandom_range(0, 1),
                   AW'({$urandom_range(0, 31), 2'b00}), $urandom);
         step();
      end
      idle();
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
